dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
Multi-cycle load/store controller between the CPU datapath and the 64x32 data RAM. It accepts one byte-addressed word request at a time over a valid/ready handshake and sequences the RAM's level-sensitive Mem_Read/Mem_Write strobes from registers. It returns read data or a completion with an error flag over a valid/ready response channel, and optionally performs byte-masked stores by read-modify-write.

Parameters:
ADDR_W, 6, RAM word-address width (64 words)
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
READ_LAT, 1, cycles Mem_Read is held before M_R_Data is sampled (range 1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables, be[i] covers wdata[8i+7:8i]; used only with RMW_EN
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  misaligned address (req_addr[1:0]!=0)
Mem_Read  out  1  RAM read strobe
Mem_Write  out  1  RAM write strobe
Mem_Addr  out  ADDR_W  RAM word address = req_addr[ADDR_W+1:2]
M_W_Data  out  32  RAM write data
M_R_Data  in  32  RAM read data

Behaviour:
- Reset (async, active-high): state=IDLE; Mem_Read, Mem_Write, Mem_Addr, M_W_Data, resp_valid, resp_rdata, resp_err all 0. req_ready=1 once in IDLE.
- All RAM-side outputs are driven directly from flops; no combinational path from req_* to Mem_*.
- Mem_Read and Mem_Write are never high in the same cycle.
- The RAM writes while Mem_Write is level-high, so Mem_Addr and M_W_Data are stable for the whole Mem_Write cycle.
- req_ready = (state==IDLE). A request is accepted on a cycle with req_valid && req_ready; the address, data, we and be are latched at that point.
- FSM states: IDLE, RD, WR, RESP; with RMW_EN also RMW_RD and RMW_WR.
- IDLE -> RESP when the request is misaligned. No Mem strobe is issued; resp_err=1 and resp_rdata=0.
- IDLE -> RD on an aligned load. Mem_Read=1 for exactly READ_LAT cycles. M_R_Data is sampled at the end of the last cycle into resp_rdata. The state then moves to RESP.
- IDLE -> WR on an aligned store. Mem_Write=1 for exactly one cycle with M_W_Data=req_wdata. The state then moves to RESP.
- RESP: resp_valid=1, and the response is held stable until resp_ready. On the handshake, resp_valid drops and the state returns to IDLE. A new request is accepted no earlier than the cycle after the response is taken.
- Latency from acceptance to resp_valid: load = READ_LAT+1 cycles; store = 2 cycles; error = 1 cycle.
- req_valid while not ready: the request is ignored. The requester must hold the request stable.
- Address wrap: not possible. The byte-address width maps exactly onto the RAM.
- Reset mid-operation: strobes drop immediately (async) and the transaction is discarded with no response. A store interrupted in WR may leave that RAM word updated or not updated; software must not rely on either outcome.

Optional Feature:
Macro RMW_EN.
- Defined: an aligned store with req_be!=4'hF goes IDLE -> RMW_RD, which holds Mem_Read for READ_LAT cycles and captures the old word. It then goes to RMW_WR, which drives Mem_Write for one cycle with merged data (new bytes where be=1, old bytes elsewhere), then to RESP. Store latency becomes READ_LAT+2. req_be=4'h0 skips the RAM entirely and completes in 1 cycle. req_be=4'hF uses the plain WR path.
- Undefined: req_be is ignored, every store writes the full word, and the RMW states do not exist.

Decomposition:
- Package dmem_ctrl_pkg: FSM state encoding, BYTE_LANES=4, OFFSET_BITS=2.
- Sub-module be_merge: combinational old/new byte merge on 4 lanes, instantiated only under RMW_EN.

Test Plan:
- Store 0x12345678 at byte addr 0x08, then load 0x08. Required: Mem_Write high for 1 cycle with Mem_Addr=2; load resp_rdata=0x12345678, resp_err=0, resp_valid at cycle READ_LAT+1.
- Load at byte addr 0x05. Required: resp_valid the next cycle, resp_err=1, resp_rdata=0, Mem_Read and Mem_Write never asserted.
- Hold resp_ready=0 for 5 cycles after a load. Required: resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored.
- Back-to-back store/load to addr 0xFC (Mem_Addr=63). Required: correct data, no overlap of Mem_Read and Mem_Write.
- With RMW_EN: word 0xAABBCCDD, store 0x00001100 with be=4'b0010. Required: read-back 0xAABB11DD.
- Assert rst during RD. Required: Mem_Read=0 immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// RMW_EN adds the read-modify-write states used for byte-masked stores.
package dmem_ctrl_pkg;

  localparam int unsigned BYTE_LANES  = 4;
  localparam int unsigned OFFSET_BITS = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StWr    = 3'd2,
    StResp  = 3'd3
`ifdef RMW_EN
    ,
    StRmwRd = 3'd4,
    StRmwWr = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/be_merge.sv
// Combinational byte-lane merge: lanes with be set take the new byte, the rest keep the old byte.
module be_merge
  import dmem_ctrl_pkg::*;
(
  input  logic [8*BYTE_LANES-1:0] old_data,
  input  logic [8*BYTE_LANES-1:0] new_data,
  input  logic [BYTE_LANES-1:0]   be,
  output logic [8*BYTE_LANES-1:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer between the datapath and the 64x32 data RAM.
// Define RMW_EN to enable byte-masked stores via read-modify-write.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W+OFFSET_BITS-1:0] req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [BYTE_LANES-1:0]         req_be,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic                          Mem_Read,
  output logic                          Mem_Write,
  output logic [ADDR_W-1:0]             Mem_Addr,
  output logic [DATA_W-1:0]             M_W_Data,
  input  logic [DATA_W-1:0]             M_R_Data
);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   m_w_data_q, m_w_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aligned;
  logic                last_rd;

  assign aligned = (req_addr[OFFSET_BITS-1:0] == '0);
  assign last_rd = (cnt_q == 2'(READ_LAT - 1));

`ifdef RMW_EN
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [DATA_W-1:0]     merged;

  be_merge u_be_merge (
    .old_data (M_R_Data),
    .new_data (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );
`else
  // Byte enables only matter for read-modify-write stores.
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    m_w_data_d  = m_w_data_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef RMW_EN
    wdata_d     = wdata_q;
    be_d        = be_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!aligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            mem_addr_d = req_addr[ADDR_W+OFFSET_BITS-1:OFFSET_BITS];
            if (!req_we) begin
              state_d    = StRd;
              mem_read_d = 1'b1;
            end
`ifdef RMW_EN
            else if (req_be == '0) begin
              state_d = StResp;
            end else if (req_be != '1) begin
              state_d    = StRmwRd;
              mem_read_d = 1'b1;
              wdata_d    = req_wdata;
              be_d       = req_be;
            end
`endif
            else begin
              state_d     = StWr;
              mem_write_d = 1'b1;
              m_w_data_d  = req_wdata;
            end
          end
        end
      end
      StRd: begin
        if (last_rd) begin
          rdata_d = M_R_Data;
          state_d = StResp;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_read_d = 1'b1;
        end
      end
      StWr: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
`ifdef RMW_EN
      StRmwRd: begin
        // Merged word is registered so M_W_Data is stable for the whole write cycle.
        if (last_rd) begin
          m_w_data_d  = merged;
          mem_write_d = 1'b1;
          state_d     = StRmwWr;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_read_d = 1'b1;
        end
      end
      StRmwWr: state_d = StResp;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      m_w_data_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef RMW_EN
      wdata_q     <= '0;
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      m_w_data_q  <= m_w_data_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef RMW_EN
      wdata_q     <= wdata_d;
      be_q        <= be_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign Mem_Read   = mem_read_q;
  assign Mem_Write  = mem_write_q;
  assign Mem_Addr   = mem_addr_q;
  assign M_W_Data   = m_w_data_q;

endmodule
